// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic datapaths.
// Holds the sequencer state encoding and the counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 1- or 2-bit operand still needs one counter bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of serial_subtractor.
// The ovf line exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERSUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin.
// Purely combinational; bout is the borrow into the next bit.
module full_subtractor (
    output logic bout,
    output logic diff,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, one result bit per clock.
// Optional signed overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    serial_subtractor_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_nxt;
    logic             bout_r;
    logic             d;
    logic             accept;
    logic             last;

    full_subtractor u_cell (
        .bout (brw_nxt),
        .diff (d),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw)
    );

    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: starts are honoured only outside RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial shift and result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            diff_r <= WIDTH'({d, diff_r} >> 1);
            brw    <= brw_nxt;
            if (last) begin
                bout_r <= brw_nxt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SERSUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_r;

    // Signed overflow from the captured operand signs and the last diff bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (last) begin
            ovf_r <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH 4, 1, 8.
// Overflow checks are compiled in when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic bi, output int lat, output int nbusy);
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.bin = bi; bus4.start = 1'b1;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            if (bus4.busy) nbusy++;
            if (bus4.done) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL op4_timeout: no done within 20 cycles");
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic bi,
                       output int lat, output int nbusy);
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.bin = bi; bus1.start = 1'b1;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.busy) nbusy++;
            if (bus1.done) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL op1_timeout: no done within 20 cycles");
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic bi, output int lat);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.bin = bi; bus8.start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.done) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL op8_timeout: no done within 30 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus4.busy, bus4.done, bus4.diff, bus4.bout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b want all 0",
                     bus4.busy, bus4.done, bus4.diff, bus4.bout);
        end
`ifdef SERSUB_OVF_EN
        checks++;
        if (bus4.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", bus4.ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nb;
        op4(4'd9, 4'd3, 1'b0, lat, nb);
        checks++;
        if (lat != 5 || nb != 4) begin
            errors++;
            $display("FAIL timing_9m3: got lat=%0d busy=%0d want lat=5 busy=4", lat, nb);
        end
        checks++;
        if (bus4.diff !== 4'd6 || bus4.bout !== 1'b0) begin
            errors++;
            $display("FAIL diff_9m3: got %h/%b want 6/0", bus4.diff, bus4.bout);
        end
        @(negedge clk);
        checks++;
        if (bus4.done !== 1'b0 || bus4.diff !== 4'd6) begin
            errors++;
            $display("FAIL hold_9m3: got done=%b diff=%h want 0/6", bus4.done, bus4.diff);
        end
        op4(4'd3, 4'd9, 1'b0, lat, nb);
        checks++;
        if (bus4.diff !== 4'hA || bus4.bout !== 1'b1) begin
            errors++;
            $display("FAIL diff_3m9: got %h/%b want a/1", bus4.diff, bus4.bout);
        end
        op4(4'd0, 4'd0, 1'b1, lat, nb);
        checks++;
        if (bus4.diff !== 4'hF || bus4.bout !== 1'b1) begin
            errors++;
            $display("FAIL diff_0m0b: got %h/%b want f/1", bus4.diff, bus4.bout);
        end
    endtask

    task automatic test_back_to_back();
        int t_done [2];
        logic [3:0] dv [2];
        logic bv [2];
        int n = 0;
        @(negedge clk);
        bus4.a = 4'd7; bus4.b = 4'd2; bus4.bin = 1'b0; bus4.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 2) bus4.a = 4'd1;
            if (bus4.done && n < 2) begin
                t_done[n] = c; dv[n] = bus4.diff; bv[n] = bus4.bout; n++;
            end
            if (c == 10) bus4.start = 1'b0;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses want 2", n);
        end else begin
            checks++;
            if (t_done[1] - t_done[0] != 5) begin
                errors++;
                $display("FAIL b2b_gap: got %0d want 5", t_done[1] - t_done[0]);
            end
            checks++;
            if (dv[0] !== 4'd5 || bv[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first: got %h/%b want 5/0", dv[0], bv[0]);
            end
            checks++;
            if (dv[1] !== 4'hF || bv[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second: got %h/%b want f/1", dv[1], bv[1]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat, nb;
        int seen = 0;
        @(negedge clk);
        bus4.a = 4'd12; bus4.b = 4'd5; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus4.busy !== 1'b0 || bus4.diff !== 4'd0 || bus4.bout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got busy=%b diff=%h bout=%b want 0/0/0",
                     bus4.busy, bus4.diff, bus4.bout);
        end
        for (int i = 0; i < 8; i++) begin
            if (bus4.done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_nodone: got %0d done cycles want 0", seen);
        end
        op4(4'd12, 4'd5, 1'b0, lat, nb);
        checks++;
        if (bus4.diff !== 4'd7 || bus4.bout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_redo: got %h/%b want 7/0", bus4.diff, bus4.bout);
        end
    endtask

`ifdef SERSUB_OVF_EN
    task automatic test_ovf();
        int lat, nb;
        op4(4'd8, 4'd1, 1'b0, lat, nb);
        checks++;
        if (bus4.diff !== 4'd7 || bus4.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_8m1: got %h/%b want 7/1", bus4.diff, bus4.ovf);
        end
        op4(4'd5, 4'd2, 1'b0, lat, nb);
        checks++;
        if (bus4.diff !== 4'd3 || bus4.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_5m2: got %h/%b want 3/0", bus4.diff, bus4.ovf);
        end
    endtask
`endif

    task automatic test_width1();
        int lat, nb;
        op1(1'b0, 1'b1, 1'b0, lat, nb);
        checks++;
        if (nb != 1 || lat != 2) begin
            errors++;
            $display("FAIL w1_timing: got busy=%0d lat=%0d want 1/2", nb, lat);
        end
        checks++;
        if (bus1.diff !== 1'b1 || bus1.bout !== 1'b1) begin
            errors++;
            $display("FAIL w1_result: got %b/%b want 1/1", bus1.diff, bus1.bout);
        end
        op1(1'b1, 1'b0, 1'b0, lat, nb);
        checks++;
        if (bus1.diff !== 1'b1 || bus1.bout !== 1'b0) begin
            errors++;
            $display("FAIL w1_1m0: got %b/%b want 1/0", bus1.diff, bus1.bout);
        end
    endtask

    task automatic test_random8();
        int lat;
        logic [7:0] a, b;
        logic bi;
        logic [8:0] exp;
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            if (k == 0) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
            if (k == 1) begin a = 8'hFF; b = 8'h00; bi = 1'b0; end
            exp = {1'b0, a} - {1'b0, b} - {8'd0, bi};
            op8(a, b, bi, lat);
            checks++;
            if (bus8.diff !== exp[7:0] || bus8.bout !== exp[8]) begin
                errors++;
                $display("FAIL rand8 %h-%h-%b: got %h/%b want %h/%b",
                         a, b, bi, bus8.diff, bus8.bout, exp[7:0], exp[8]);
            end
        end
    endtask

    initial begin
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_mid_reset();
`ifdef SERSUB_OVF_EN
        test_ovf();
`endif
        test_width1();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
